ccd_adc_capture: RTL
====================

# ccd_adc_capture

Serial-ADC readout stage downstream of the ILX511B CCD timing generator. Consumes `flag_adc_start` (one pulse per pixel) and `flag_adc_restart` (one pulse per acquisition). Runs one conversion-plus-serial-read cycle on the external ADC per start pulse, then writes the resulting pixel word into the spectrum buffer at a sequential address. Signals frame completion and flags overruns.

## Interface
Parameters:
- `ADC_BITS`, 16: ADC result width, MSB first on `adc_sdo`.
- `CONV_CYCLES`, 40: number of `sys_clk` cycles that `adc_cnv` is held high.
- `SCLK_DIV`, 2: `sys_clk` cycles per SCLK half-period (≥1).
- `NUM_PIXELS`, 2048: pixel writes per frame.
- `ADDR_W`, 12: buffer address width; 2^ADDR_W ≥ NUM_PIXELS.
- `DUMMY_PIXELS`, 32: leading conversions discarded (only with `CCD_DUMMY_SKIP_EN`).

Ports:
- `sys_clk` in 1: single system clock; all logic on its rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `flag_adc_start` in 1: one-cycle pulse, start one pixel conversion.
- `flag_adc_restart` in 1: one-cycle pulse, new acquisition; rearm frame.
- `adc_cnv` out 1: ADC convert strobe.
- `adc_sclk` out 1: ADC serial clock, idles low.
- `adc_sdo` in 1: ADC serial data; already synchronous to `sys_clk`.
- `pix_wr_en` out 1: one-cycle buffer write strobe.
- `pix_wr_addr` out ADDR_W: pixel index for the write.
- `pix_wr_data` out ADC_BITS: pixel value.
- `frame_done` out 1: one-cycle pulse after the last pixel write.
- `overrun` out 1: sticky; a start arrived while busy.
- `busy` out 1: high in every state except IDLE and DONE.

## Operation
- FSM states: IDLE, CONV, SHIFT, WRITE, DONE.
- IDLE → CONV on `flag_adc_start`. `adc_cnv`=1 for exactly CONV_CYCLES cycles.
- CONV → SHIFT.
  - ADC_BITS SCLK periods; each period is SCLK_DIV cycles low then SCLK_DIV cycles high.
  - `adc_sdo` is sampled into the shift register in the cycle `adc_sclk` goes 0→1.
  - The first sample is the MSB.
- SHIFT → WRITE after the last high half-period. `adc_sclk` returns low.
- WRITE: one cycle.
  - `pix_wr_en`=1, `pix_wr_data`=shift register, `pix_wr_addr`=pixel counter.
  - The pixel counter increments after the write.
  - Next state is IDLE, or DONE if this was write NUM_PIXELS−1; `frame_done` pulses in the cycle DONE is entered.
- DONE: `flag_adc_start` is ignored and does not set `overrun`. Only restart leaves DONE.
- `flag_adc_start` in CONV/SHIFT/WRITE: the pulse is dropped and `overrun`←1. The current conversion completes unaffected.
- `flag_adc_restart` in any state:
  - next state IDLE, pixel counter←0, dummy counter←0, `overrun`←0;
  - `adc_cnv` and `adc_sclk` are forced low next cycle;
  - an in-flight pixel is discarded with no write.
- Restart and start in the same cycle: restart wins; the start is dropped and does not set `overrun`.
- Arithmetic:
  - The pixel counter is ADDR_W bits and never exceeds NUM_PIXELS−1 at a write, so it never wraps.
  - Bit counter and divider counters are sized with `$clog2` of their terminal values.

## Timing
- Reset values: `adc_cnv`=0, `adc_sclk`=0, `pix_wr_en`=0, `pix_wr_addr`=0, `pix_wr_data`=0, `frame_done`=0, `overrun`=0, `busy`=0; FSM in IDLE.
- Start seen at edge N: `adc_cnv` high in cycles N+1 … N+CONV_CYCLES.
- First `adc_sclk` rise at N+CONV_CYCLES+SCLK_DIV+1.
- `pix_wr_en` at N+CONV_CYCLES+2·SCLK_DIV·ADC_BITS+1.
- Defaults: write at N+105; next start accepted from N+106 (IDLE).
- Minimum start spacing without overrun is CONV_CYCLES+2·SCLK_DIV·ADC_BITS+1 cycles.
- All outputs are registered.

## Configuration
- `CCD_DUMMY_SKIP_EN` defined: the first DUMMY_PIXELS conversions after restart/reset run the full CONV/SHIFT sequence, but WRITE is suppressed (`pix_wr_en`=0, counter unchanged). A frame then needs DUMMY_PIXELS+NUM_PIXELS starts.
- Not defined: every conversion is written, and DUMMY_PIXELS is unused.

## Test plan
- Single pixel:
  - Stimulus: reset, restart, one start; `adc_sdo` model drives 0xA5C3 MSB first.
  - Required: `adc_cnv` high 40 cycles, 16 SCLK periods, one `pix_wr_en` 105 cycles after the start with addr 0, data 0xA5C3.
- Full frame:
  - Stimulus: 2048 starts spaced 120 cycles, each pixel value = its index.
  - Required: addrs 0…2047 in order, data matches, one `frame_done` after write 2047; a 2049th start produces no write and `overrun`=0.
- Overrun:
  - Stimulus: a second start 50 cycles after the first.
  - Required: `overrun`=1 and stays 1, only one write; the first pixel's data is intact.
- Restart mid-SHIFT:
  - Stimulus: restart 70 cycles after a start, at pixel 5.
  - Required: no write, `adc_sclk`/`adc_cnv` low next cycle, `overrun` cleared; the next start writes addr 0.
- Simultaneous restart+start while in SHIFT: FSM returns to IDLE, `overrun` stays 0, no conversion starts.
- With `CCD_DUMMY_SKIP_EN`: 32+3 starts give exactly 3 writes, at addrs 0,1,2, with the values from conversions 33–35.

Source files
------------

// File: rtl/ccd_adc_capture_if.sv
// Capture-block signal bundle: pixel trigger flags, serial-ADC pins, buffer write port, status.
// Latency: none, wires only.
// Backpressure: none; the capture block flags dropped starts through overrun instead of stalling.
interface ccd_adc_capture_if #(
  parameter int ADC_BITS = 16,
  parameter int ADDR_W   = 12
);
  logic                flag_adc_start;
  logic                flag_adc_restart;
  logic                adc_cnv;
  logic                adc_sclk;
  logic                adc_sdo;
  logic                pix_wr_en;
  logic [ADDR_W-1:0]   pix_wr_addr;
  logic [ADC_BITS-1:0] pix_wr_data;
  logic                frame_done;
  logic                overrun;
  logic                busy;

  // Capture block side
  modport master (
    input  flag_adc_start, flag_adc_restart, adc_sdo,
    output adc_cnv, adc_sclk, pix_wr_en, pix_wr_addr, pix_wr_data,
           frame_done, overrun, busy
  );

  // Timing generator / ADC / buffer side
  modport slave (
    output flag_adc_start, flag_adc_restart, adc_sdo,
    input  adc_cnv, adc_sclk, pix_wr_en, pix_wr_addr, pix_wr_data,
           frame_done, overrun, busy
  );
endinterface

// File: rtl/ccd_adc_capture.sv
// Serial-ADC pixel capture: one convert + MSB-first serial read per start pulse, written to the spectrum buffer.
// Latency: write strobe CONV_CYCLES + 2*SCLK_DIV*ADC_BITS + 1 cycles after the start; all outputs registered.
// Backpressure: none; starts while busy are dropped and latch overrun. Define CCD_DUMMY_SKIP_EN to discard leading dummy pixels.
module ccd_adc_capture #(
  parameter int ADC_BITS     = 16,
  parameter int CONV_CYCLES  = 40,
  parameter int SCLK_DIV     = 2,
  parameter int NUM_PIXELS   = 2048,
  parameter int ADDR_W       = 12,
  parameter int DUMMY_PIXELS = 32
) (
  input logic               sys_clk,
  input logic               sys_rst,
  ccd_adc_capture_if.master bus
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;

  // Number of leading conversions thrown away after restart/reset.
`ifdef CCD_DUMMY_SKIP_EN
  localparam int SKIP_N = DUMMY_PIXELS;
`else
  localparam int SKIP_N = 0 * DUMMY_PIXELS;
`endif

  typedef enum logic [2:0] {IDLE, CONV, SHIFT, WRITE, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       conv_cnt;
  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [ADC_BITS-1:0] shreg;
  logic [ADDR_W-1:0]   pix_cnt;
  logic                cnv_q, sclk_q, wr_en_q, frame_done_q, overrun_q, busy_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADC_BITS-1:0] wr_data_q;

  logic start, restart;
  logic last_conv, half_end, shift_end, set_ovr, enter_write, skip_pix;

  assign start   = bus.flag_adc_start;
  assign restart = bus.flag_adc_restart;

  assign bus.adc_cnv     = cnv_q;
  assign bus.adc_sclk    = sclk_q;
  assign bus.pix_wr_en   = wr_en_q;
  assign bus.pix_wr_addr = wr_addr_q;
  assign bus.pix_wr_data = wr_data_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = busy_q;

  // Next-state decode; restart overrides everything, including a same-cycle start.
  always_comb begin
    state_nxt   = state;
    set_ovr     = 1'b0;
    enter_write = 1'b0;
    last_conv   = (conv_cnt == CW'(CONV_CYCLES - 1));
    half_end    = (div_cnt == DW'(SCLK_DIV - 1));
    shift_end   = sclk_q && half_end && (bit_cnt == BW'(ADC_BITS - 1));
    case (state)
      IDLE:  if (start) state_nxt = CONV;
      CONV: begin
        set_ovr = start;
        if (last_conv) state_nxt = SHIFT;
      end
      SHIFT: begin
        set_ovr = start;
        if (shift_end) begin
          state_nxt   = WRITE;
          enter_write = !skip_pix;
        end
      end
      WRITE: begin
        set_ovr   = start;
        state_nxt = (wr_en_q && (pix_cnt == ADDR_W'(NUM_PIXELS - 1))) ? DONE : IDLE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (restart) begin
      state_nxt   = IDLE;
      set_ovr     = 1'b0;
      enter_write = 1'b0;
    end
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Convert strobe, serial clock generation, shift register and write port
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      conv_cnt     <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      pix_cnt      <= '0;
      cnv_q        <= 1'b0;
      sclk_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_en_q      <= enter_write;
      frame_done_q <= (state == WRITE) && (state_nxt == DONE);
      busy_q       <= state_nxt inside {CONV, SHIFT, WRITE};

      if (enter_write) begin
        wr_addr_q <= pix_cnt;
        wr_data_q <= shreg;
      end

      if (restart)                            cnv_q <= 1'b0;
      else if (state == IDLE && start)        cnv_q <= 1'b1;
      else if (state == CONV && last_conv)    cnv_q <= 1'b0;

      conv_cnt <= (state == CONV) ? conv_cnt + 1'b1 : '0;

      // Low half first; the sample is taken on the edge that raises sclk.
      if (state == SHIFT && !restart) begin
        if (half_end) begin
          div_cnt <= '0;
          sclk_q  <= !sclk_q;
          if (!sclk_q) shreg   <= {shreg[ADC_BITS-2:0], bus.adc_sdo};
          else         bit_cnt <= bit_cnt + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk_q  <= 1'b0;
      end

      // Counter stops at the last index so it never wraps; restart rearms it.
      if (restart)
        pix_cnt <= '0;
      else if (state == WRITE && wr_en_q && pix_cnt != ADDR_W'(NUM_PIXELS - 1))
        pix_cnt <= pix_cnt + 1'b1;

      if (restart)      overrun_q <= 1'b0;
      else if (set_ovr) overrun_q <= 1'b1;
    end
  end

  if (SKIP_N > 0) begin : g_skip
    localparam int KW = $clog2(SKIP_N + 1);
    logic [KW-1:0] dummy_cnt;

    assign skip_pix = (dummy_cnt < KW'(SKIP_N));

    // Count discarded conversions as they pass through WRITE
    always_ff @(posedge sys_clk) begin
      if (sys_rst || restart)               dummy_cnt <= '0;
      else if (state == WRITE && skip_pix)  dummy_cnt <= dummy_cnt + 1'b1;
    end
  end else begin : g_noskip
    assign skip_pix = 1'b0;
  end

endmodule
